// File: rtl/usb_tx_sched.sv
// Purpose : launches one USB packet at a time from the handshake responder or the host onto tx_packet.
// Latency : grant is registered 1 cycle after a request is seen in IDLE; the PID reaches tx_packet 1 cycle later.
// Backpress: requests are only accepted in IDLE with idle=1; anything else is held off by simply not granting.
//
// Ports:
//   clk, n_rst                  clock and synchronous active-low reset
//   hs_req/hs_pid               handshake responder request (level) and PID
//   host_req/host_pid           host request (level) and PID
//   buffer_occupancy            TX FIFO byte count, used to reject empty DATA packets
//   tx_transfer_active/tx_error/idle  status from the TX FSM
//   *_grant/*_done/*_err        registered one-cycle pulses per requester
//   tx_packet                   PID handed to the TX FSM, 0 = nothing to send
//   busy                        high whenever the scheduler is not in IDLE
module usb_tx_sched #(
    parameter int GAP_CYCLES     = 4,
    parameter int LAUNCH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_grant,
    output logic       hs_done,
    output logic       hs_err,
    input  logic       host_req,
    input  logic [3:0] host_pid,
    output logic       host_grant,
    output logic       host_done,
    output logic       host_err,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic       idle,
    output logic [3:0] tx_packet,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ACTIVE, S_GAP} state_t;

    state_t     state_q, state_d;
    logic [3:0] pid_q, pid_d;
    logic       owner_hs_q, owner_hs_d;
    logic       err_q, err_d;
    logic [7:0] launch_cnt_q, launch_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] tx_packet_q, tx_packet_d;
    logic       busy_q, busy_d;
    logic       hs_grant_q, hs_grant_d;
    logic       hs_done_q, hs_done_d;
    logic       hs_err_q, hs_err_d;
    logic       host_grant_q, host_grant_d;
    logic       host_done_q, host_done_d;
    logic       host_err_q, host_err_d;

    // Completion of the current owner's packet, steered to the right requester below.
    logic       fin, fin_err;
    logic       host_reject;

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        owner_hs_d   = owner_hs_q;
        err_d        = err_q;
        launch_cnt_d = launch_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tx_packet_d  = 4'd0;
        hs_grant_d   = 1'b0;
        hs_done_d    = 1'b0;
        hs_err_d     = 1'b0;
        host_grant_d = 1'b0;
        host_done_d  = 1'b0;
        host_err_d   = 1'b0;
        fin          = 1'b0;
        fin_err      = 1'b0;
        // An empty FIFO cannot feed a DATA packet; refuse it here rather than
        // letting the TX FSM take its error path.
        host_reject  = (host_pid == 4'd0) ||
                       ((host_pid[2:0] == 3'b011) && (buffer_occupancy == 7'd0));

        case (state_q)
            S_IDLE: begin
                // A done pulse on the output means the requester may still be
                // holding req this cycle; skip arbitration so it is not seen twice.
                if (idle && !(hs_done_q || host_done_q)) begin
                    if (hs_req) begin
                        if (hs_pid == 4'd0) begin
                            hs_done_d = 1'b1;
                            hs_err_d  = 1'b1;
                        end else begin
                            pid_d        = hs_pid;
                            owner_hs_d   = 1'b1;
                            err_d        = 1'b0;
                            launch_cnt_d = 8'd0;
                            hs_grant_d   = 1'b1;
                            state_d      = S_LAUNCH;
                        end
                    end else if (host_req) begin
                        if (host_reject) begin
                            host_done_d = 1'b1;
                            host_err_d  = 1'b1;
                        end else begin
                            pid_d        = host_pid;
                            owner_hs_d   = 1'b0;
                            err_d        = 1'b0;
                            launch_cnt_d = 8'd0;
                            host_grant_d = 1'b1;
                            state_d      = S_LAUNCH;
                        end
                    end
                end
            end
            S_LAUNCH: begin
                tx_packet_d = pid_q;
                if (tx_transfer_active) begin
                    state_d = S_ACTIVE;
                end else if (launch_cnt_q == 8'(LAUNCH_TIMEOUT - 1)) begin
                    tx_packet_d = 4'd0;
                    fin         = 1'b1;
                    fin_err     = 1'b1;
                    gap_cnt_d   = 4'd0;
                    state_d     = S_GAP;
                end else begin
                    launch_cnt_d = launch_cnt_q + 8'd1;
                end
            end
            S_ACTIVE: begin
                tx_packet_d = pid_q;
                err_d       = err_q | tx_error;
                if (!tx_transfer_active) begin
                    // Dropping the PID right away keeps the TX FSM from relaunching
                    // once its post-EOP delay expires.
                    tx_packet_d = 4'd0;
                    fin         = 1'b1;
                    fin_err     = err_q | tx_error;
                    gap_cnt_d   = 4'd0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                // The gap must be contiguous idle time; any busy cycle restarts it.
                if (idle) begin
                    if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                        gap_cnt_d = 4'd0;
                        state_d   = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end else begin
                    gap_cnt_d = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            if (owner_hs_q) begin
                hs_done_d = 1'b1;
                hs_err_d  = fin_err;
            end else begin
                host_done_d = 1'b1;
                host_err_d  = fin_err;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            pid_q        <= 4'd0;
            owner_hs_q   <= 1'b0;
            err_q        <= 1'b0;
            launch_cnt_q <= 8'd0;
            gap_cnt_q    <= 4'd0;
            tx_packet_q  <= 4'd0;
            busy_q       <= 1'b0;
            hs_grant_q   <= 1'b0;
            hs_done_q    <= 1'b0;
            hs_err_q     <= 1'b0;
            host_grant_q <= 1'b0;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pid_q        <= pid_d;
            owner_hs_q   <= owner_hs_d;
            err_q        <= err_d;
            launch_cnt_q <= launch_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_packet_q  <= tx_packet_d;
            busy_q       <= busy_d;
            hs_grant_q   <= hs_grant_d;
            hs_done_q    <= hs_done_d;
            hs_err_q     <= hs_err_d;
            host_grant_q <= host_grant_d;
            host_done_q  <= host_done_d;
            host_err_q   <= host_err_d;
        end
    end

    assign tx_packet  = tx_packet_q;
    assign busy       = busy_q;
    assign hs_grant   = hs_grant_q;
    assign hs_done    = hs_done_q;
    assign hs_err     = hs_err_q;
    assign host_grant = host_grant_q;
    assign host_done  = host_done_q;
    assign host_err   = host_err_q;

endmodule
